// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the writeback register file: write-source encodings
// and the hard-wired zero register index.
package wb_regfile_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC8  = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_core.sv
// Register storage with one write port and two raw asynchronous read ports.
// Register 0 is never written, so it always holds zero.
module wb_regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [REG_AW-1:0] raddrA_i,
    input  logic [REG_AW-1:0] raddrB_i,
    output logic [DW-1:0]     rdataA_o,
    output logic [DW-1:0]     rdataB_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = regs_q[raddrA_i];
    assign rdataB_o = regs_q[raddrB_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: write-source mux, write-through read bypass,
// retired-instruction counter and a registered copy of each committed write.
// Define WB_TRACE_EN to print one trace line per committed write.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [31:0]       wb_instr,
    input  logic [31:0]       wb_pc,
    input  logic [REG_AW-1:0] wb_regaddr,
    input  logic [1:0]        wb_sel,
    input  logic [DW-1:0]     wb_aluout,
    input  logic [DW-1:0]     wb_memdata,
    input  logic [DW-1:0]     wb_pc8,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DW-1:0]     rs_data,
    output logic [DW-1:0]     rt_data,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_addr_o,
    output logic [DW-1:0]     wr_data_o,
    output logic [31:0]       retire_cnt
);

    logic              wrCommit;
    logic [DW-1:0]     wrData;
    logic [DW-1:0]     rawRs;
    logic [DW-1:0]     rawRt;
    logic [31:0]       retireCnt_q, retireCnt_d;
    logic              wrEn_q;
    logic [REG_AW-1:0] wrAddr_q;
    logic [DW-1:0]     wrData_q;
    logic              unused_trace;

    // The instruction word is carried for tracing only.
    assign unused_trace = ^{wb_instr, wb_pc};

    always_comb begin
        wrData = wb_aluout;
        case (wb_sel)
            WB_SEL_MEM: wrData = wb_memdata;
            WB_SEL_PC8: wrData = wb_pc8;
            default:    wrData = wb_aluout;
        endcase
    end

    assign wrCommit = reset && wb_valid && (wb_regaddr != REG_ZERO) && (wb_sel != WB_SEL_NONE);

    wb_regfile_core #(
        .DW   (DW),
        .NREG (NREG)
    ) u_core (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (wrCommit),
        .waddr_i  (wb_regaddr),
        .wdata_i  (wrData),
        .raddrA_i (rs_addr),
        .raddrB_i (rt_addr),
        .rdataA_o (rawRs),
        .rdataB_o (rawRt)
    );

    // Same bypass rule on both ports keeps rs/rt identical when their addresses match.
    always_comb begin
        rs_data = rawRs;
        rt_data = rawRt;
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wrCommit && (wb_regaddr == rs_addr)) begin
            rs_data = wrData;
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wrCommit && (wb_regaddr == rt_addr)) begin
            rt_data = wrData;
        end
    end

    assign retireCnt_d = wb_valid ? retireCnt_q + 32'd1 : retireCnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireCnt_q <= '0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
        end else begin
            retireCnt_q <= retireCnt_d;
            wrEn_q      <= wrCommit;
            wrAddr_q    <= wrCommit ? wb_regaddr : '0;
            wrData_q    <= wrCommit ? wrData : '0;
        end
    end

    assign retire_cnt = retireCnt_q;
    assign wr_en_o    = wrEn_q;
    assign wr_addr_o  = wrAddr_q;
    assign wr_data_o  = wrData_q;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (wrCommit) begin
            $display("@%08h: $%02d <= %08h", wb_pc, wb_regaddr, wrData);
        end
    end
`else
    // Trace output is compiled out in this build.
`endif

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DW, default 32: datapath width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, addressed by 5 bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port wb_valid, input, 1: WB stage holds a real instruction (nonzero instr).
REQ-006 SHALL have port wb_instr, input, 32: WB instruction word (trace only).
REQ-007 SHALL have port wb_pc, input, 32: WB instruction PC.
REQ-008 SHALL have port wb_regaddr, input, 5: destination register.
REQ-009 SHALL have port wb_sel, input, 2: write-data source (00 ALU, 01 MEM, 10 PC8, 11 no write).
REQ-010 SHALL have ports wb_aluout, wb_memdata, wb_pc8, input, 32 each: candidate write data.
REQ-011 SHALL have ports rs_addr and rt_addr, input, 5 each: read addresses from decode.
REQ-012 SHALL have ports rs_data and rt_data, output, 32 each: read data.
REQ-013 SHALL have ports wr_en_o (1), wr_addr_o (5) and wr_data_o (32), output: registered copy of the last committed write.
REQ-014 SHALL have port retire_cnt, output, 32: count of retired instructions.

Function
REQ-015 Write data SHALL be combinational: selected from wb_aluout, wb_memdata or wb_pc8 by wb_sel.
REQ-016 A write SHALL commit at posedge clk iff wb_valid=1, wb_regaddr!=0 and wb_sel!=11.
REQ-017 Register 0 SHALL always read 0; attempted writes to it SHALL be discarded.
REQ-018 Reads SHALL be combinational, with write-through bypass: if a write qualifies this cycle and its address equals a nonzero read address, that port SHALL return the write data.
REQ-019 When rs_addr equals rt_addr, both ports SHALL return identical data, including the bypassed case.
REQ-020 wr_en_o, wr_addr_o and wr_data_o SHALL update every clock edge: one-cycle latency, wr_en_o=0 on cycles with no committed write.
REQ-021 retire_cnt SHALL increment by 1 on each edge with wb_valid=1, including r0 and no-write instructions; it SHALL wrap from FFFFFFFF to 0.
REQ-022 wb_regaddr, wb_sel and the data inputs SHALL be don't-care while wb_valid=0.

Reset
REQ-023 reset=0 SHALL immediately clear all registers 1..NREG-1, retire_cnt, wr_en_o, wr_addr_o and wr_data_o to 0, independent of clk.
REQ-024 No write and no count SHALL occur on a clock edge while reset=0.
REQ-025 Reset asserted mid-operation SHALL discard any pending write; the first edge after release SHALL behave normally.

Configuration
REQ-026 With macro WB_TRACE_EN defined, each committed write SHALL print "@<pc 8-hex>: $<addr 2-dec> <= <data 8-hex>" at the commit edge.
REQ-027 Without WB_TRACE_EN, no print SHALL occur and the logic SHALL be identical.

Structure
REQ-028 The wb_sel encodings (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC8, WB_SEL_NONE) and REG_ZERO SHALL be defined in the shared CPU package.
REQ-029 The storage array with its write port SHALL be the sub-module wb_regfile_core; bypass logic, counter and trace SHALL live in wb_regfile.

Verification
REQ-030 Assert reset=0 mid-run, then read all registers -> all reads 0, retire_cnt=0, wr_en_o=0.
REQ-031 wb_valid=1, addr=5, sel=00, aluout=12345678, with rs_addr=5 in the same cycle -> rs_data=12345678 (bypass); next cycle wr_en_o=1, wr_addr_o=5.
REQ-032 Write addr=0, sel=01, memdata=DEADBEEF -> rs_addr=0 reads 0; wr_en_o=0; retire_cnt increments.
REQ-033 sel=11 at addr=7 holding 00000011 -> r7 stays 00000011; retire_cnt increments.
REQ-034 Preload retire_cnt to FFFFFFFE, then run 3 valid cycles -> counts FFFFFFFF, 0, 1.
REQ-035 With WB_TRACE_EN: pc=00003000, addr=31, sel=10, pc8=00003008 -> prints "@00003000: $31 <= 00003008".
